// File: rtl/int_reset_sequencer_pkg.sv
// Shared codes for the interrupt/reset sequencer: source encodings, default vectors,
// FSM states and the forced-BRK opcode.
package int_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    IntSrcBrk = 2'd0,
    IntSrcIrq = 2'd1,
    IntSrcNmi = 2'd2,
    IntSrcRst = 2'd3
  } int_src_e;

  typedef enum logic [1:0] {
    StRstPend = 2'd0,
    StRun     = 2'd1,
    StSeq     = 2'd2
  } seq_state_e;

  localparam logic [15:0] VEC_NMI_DEF = 16'hFFFA;
  localparam logic [15:0] VEC_RST_DEF = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ_DEF = 16'hFFFE;
  localparam logic [7:0]  BRK_OPCODE  = 8'h00;

  // BRK shares the IRQ vector.
  function automatic logic [15:0] vec_for_src(input int_src_e    src,
                                              input logic [15:0] vec_nmi,
                                              input logic [15:0] vec_rst,
                                              input logic [15:0] vec_irq);
    case (src)
      IntSrcNmi: vec_for_src = vec_nmi;
      IntSrcRst: vec_for_src = vec_rst;
      default:   vec_for_src = vec_irq;
    endcase
  endfunction

endpackage

// File: rtl/int_reset_sequencer_sync.sv
// Multi-flop synchronizer for an asynchronous active-low pin, with an optional
// falling-edge pulse on the synchronized value.
module int_reset_sequencer_sync #(
  parameter int unsigned STAGES      = 2,
  parameter bit          EDGE_DETECT = 1'b1
) (
  input  logic clk,
  input  logic RST,
  input  logic i_async,
  output logic o_level,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!RST) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_level = r_sync[STAGES-1];

  if (EDGE_DETECT) begin : g_edge
    logic r_prev;

    always_ff @(posedge clk) begin
      if (!RST) begin
        r_prev <= 1'b1;
      end else begin
        r_prev <= r_sync[STAGES-1];
      end
    end

    assign o_fall = r_prev & ~r_sync[STAGES-1];
  end else begin : g_no_edge
    assign o_fall = 1'b0;
  end

endmodule

// File: rtl/int_reset_sequencer.sv
// Instruction-boundary interrupt/reset sequencer: forces BRK into IR for RESET/NMI/IRQ and
// supplies the vector, B flag and stack write inhibit for the resulting sequence.
module int_reset_sequencer
  import int_reset_sequencer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] VEC_NMI     = VEC_NMI_DEF,
  parameter logic [15:0] VEC_RST     = VEC_RST_DEF,
  parameter logic [15:0] VEC_IRQ     = VEC_IRQ_DEF
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        RDY,
  input  logic        NMI_n,
  input  logic        IRQ_n,
  input  logic        sr_I,
  input  logic        boundary,
  input  logic [7:0]  opcode_in,
  input  logic        vec_fetch,
  output logic [7:0]  opcode_out,
  output logic        inject,
  output logic [1:0]  int_src,
  output logic        in_seq,
  output logic [15:0] vec_addr,
  output logic        b_flag,
  output logic        wr_inhibit
);

  logic w_nmi_sync_unused;
  logic w_nmi_fall;
  logic w_irq_sync;
  logic w_irq_fall_unused;

  int_reset_sequencer_sync #(
    .STAGES     (SYNC_STAGES),
    .EDGE_DETECT(1'b1)
  ) u_nmi_sync (
    .clk    (clk),
    .RST    (RST),
    .i_async(NMI_n),
    .o_level(w_nmi_sync_unused),
    .o_fall (w_nmi_fall)
  );

  int_reset_sequencer_sync #(
    .STAGES     (SYNC_STAGES),
    .EDGE_DETECT(1'b0)
  ) u_irq_sync (
    .clk    (clk),
    .RST    (RST),
    .i_async(IRQ_n),
    .o_level(w_irq_sync),
    .o_fall (w_irq_fall_unused)
  );

  seq_state_e  r_state, w_state_d;
  logic        r_nmi_pend, w_nmi_pend_d;
  int_src_e    r_int_src, w_int_src_d;
  logic [15:0] r_vec_addr, w_vec_addr_d;
  logic        r_in_seq, w_in_seq_d;
  logic        r_b_flag, w_b_flag_d;
  logic        r_wr_inhibit, w_wr_inhibit_d;

  logic        w_irq_req;
  logic        w_take;
  logic        w_inject;
  logic        w_start;
  int_src_e    w_take_src;

  always_comb begin
    w_irq_req  = ~w_irq_sync & ~sr_I;
    // A boundary seen mid-sequence is a protocol error and must not start anything.
    w_take     = boundary & RDY & RST & (r_state != StSeq);
    w_inject   = w_take & ((r_state == StRstPend) | r_nmi_pend | w_irq_req);
    w_start    = w_inject | (w_take & (opcode_in == BRK_OPCODE));
    opcode_out = w_inject ? BRK_OPCODE : opcode_in;

    if (r_state == StRstPend) begin
      w_take_src = IntSrcRst;
    end else if (r_nmi_pend) begin
      w_take_src = IntSrcNmi;
    end else if (w_irq_req) begin
      w_take_src = IntSrcIrq;
    end else begin
      w_take_src = IntSrcBrk;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_nmi_pend_d   = r_nmi_pend;
    w_int_src_d    = r_int_src;
    w_vec_addr_d   = r_vec_addr;
    w_in_seq_d     = r_in_seq;
    w_b_flag_d     = r_b_flag;
    w_wr_inhibit_d = r_wr_inhibit;

    if (RDY) begin
      case (r_state)
        StRstPend, StRun: begin
          if (w_start) begin
            w_state_d      = StSeq;
            w_in_seq_d     = 1'b1;
            w_int_src_d    = w_take_src;
            w_vec_addr_d   = vec_for_src(w_take_src, VEC_NMI, VEC_RST, VEC_IRQ);
            w_b_flag_d     = (w_take_src == IntSrcBrk);
            w_wr_inhibit_d = (w_take_src == IntSrcRst);
          end
        end
        StSeq: begin
          if (vec_fetch) begin
            w_state_d      = StRun;
            w_in_seq_d     = 1'b0;
            w_wr_inhibit_d = 1'b0;
            if (r_int_src == IntSrcNmi) begin
              w_nmi_pend_d = 1'b0;
            end
          end else if (r_nmi_pend &&
                       (r_int_src == IntSrcBrk || r_int_src == IntSrcIrq)) begin
            w_int_src_d  = IntSrcNmi;
            w_vec_addr_d = VEC_NMI;
          end
        end
        default: w_state_d = StRstPend;
      endcase
    end

    // A fresh edge outranks the clear and is captured regardless of RDY.
    if (w_nmi_fall) begin
      w_nmi_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      r_state      <= StRstPend;
      r_nmi_pend   <= 1'b0;
      r_int_src    <= IntSrcRst;
      r_vec_addr   <= VEC_RST;
      r_in_seq     <= 1'b0;
      r_b_flag     <= 1'b0;
      r_wr_inhibit <= 1'b1;
    end else begin
      r_state      <= w_state_d;
      r_nmi_pend   <= w_nmi_pend_d;
      r_int_src    <= w_int_src_d;
      r_vec_addr   <= w_vec_addr_d;
      r_in_seq     <= w_in_seq_d;
      r_b_flag     <= w_b_flag_d;
      r_wr_inhibit <= w_wr_inhibit_d;
    end
  end

  assign inject     = w_inject;
  assign int_src    = r_int_src;
  assign in_seq     = r_in_seq;
  assign vec_addr   = r_vec_addr;
  assign b_flag     = r_b_flag;
  assign wr_inhibit = r_wr_inhibit;

endmodule

// File: tb/tb_int_reset_sequencer.sv
// Directed bench for int_reset_sequencer: reset sequence, NMI edge/hold, IRQ masking,
// BRK, NMI hijack of IRQ, RDY freeze and mid-sequence reset.
module tb_int_reset_sequencer;

  logic        clk = 1'b0;
  logic        RST, RDY, NMI_n, IRQ_n, sr_I, boundary, vec_fetch;
  logic [7:0]  opcode_in;
  logic [7:0]  opcode_out;
  logic        inject, in_seq, b_flag, wr_inhibit;
  logic [1:0]  int_src;
  logic [15:0] vec_addr;

  int n_checks = 0;
  int n_pass   = 0;
  int inj_count;

  int_reset_sequencer dut (
    .clk       (clk),
    .RST       (RST),
    .RDY       (RDY),
    .NMI_n     (NMI_n),
    .IRQ_n     (IRQ_n),
    .sr_I      (sr_I),
    .boundary  (boundary),
    .opcode_in (opcode_in),
    .vec_fetch (vec_fetch),
    .opcode_out(opcode_out),
    .inject    (inject),
    .int_src   (int_src),
    .in_seq    (in_seq),
    .vec_addr  (vec_addr),
    .b_flag    (b_flag),
    .wr_inhibit(wr_inhibit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    RST = 1'b0; RDY = 1'b1; NMI_n = 1'b1; IRQ_n = 1'b1; sr_I = 1'b1;
    boundary = 1'b0; opcode_in = 8'hA9; vec_fetch = 1'b0;
    tick(3);

    // Reset state; boundary during reset must not inject
    boundary = 1'b1; settle();
    check("rst_inject", inject, 0);
    check("rst_opcode", opcode_out, 8'hA9);
    check("rst_int_src", int_src, 3);
    check("rst_in_seq", in_seq, 0);
    check("rst_vec", vec_addr, 16'hFFFC);
    check("rst_bflag", b_flag, 0);
    check("rst_wrinh", wr_inhibit, 1);

    // 1: reset sequence
    RST = 1'b1; settle();
    check("t1_opcode", opcode_out, 8'h00);
    check("t1_inject", inject, 1);
    tick(); boundary = 1'b0;
    check("t1_int_src", int_src, 3);
    check("t1_vec", vec_addr, 16'hFFFC);
    check("t1_wrinh", wr_inhibit, 1);
    check("t1_in_seq", in_seq, 1);
    boundary = 1'b1; settle();
    check("t1_seq_bnd_inject", inject, 0);
    tick(); boundary = 1'b0;
    check("t1_seq_bnd_int_src", int_src, 3);
    vec_fetch = 1'b1; tick(); vec_fetch = 1'b0;
    check("t1_end_in_seq", in_seq, 0);
    check("t1_end_wrinh", wr_inhibit, 0);
    boundary = 1'b1; opcode_in = 8'hA9; settle();
    check("t1_run_inject", inject, 0);
    check("t1_run_opcode", opcode_out, 8'hA9);
    tick(); boundary = 1'b0;
    check("t1_run_in_seq", in_seq, 0);

    // 2: NMI held low gives exactly one injection
    NMI_n = 1'b0;
    tick(3);
    inj_count = 0;
    opcode_in = 8'h4C;
    for (int i = 0; i < 20; i++) begin
      boundary  = (i % 4 == 0);
      vec_fetch = (i % 4 == 2);
      settle();
      if (boundary && inject) inj_count++;
      if (i >= 4 && boundary) check("t2_pass_opcode", opcode_out, 8'h4C);
      tick();
      boundary = 1'b0; vec_fetch = 1'b0;
      if (i == 0) begin
        check("t2_vec", vec_addr, 16'hFFFA);
        check("t2_int_src", int_src, 2);
      end
    end
    check("t2_inj_count", inj_count, 1);
    NMI_n = 1'b1;
    tick(3);

    // 3: IRQ masked by sr_I, then taken
    IRQ_n = 1'b0; sr_I = 1'b1;
    tick(3);
    boundary = 1'b1; opcode_in = 8'hEA; settle();
    check("t3_masked_inject", inject, 0);
    check("t3_masked_opcode", opcode_out, 8'hEA);
    tick();
    check("t3_masked_in_seq", in_seq, 0);
    sr_I = 1'b0; settle();
    check("t3_inject", inject, 1);
    tick(); boundary = 1'b0;
    check("t3_vec", vec_addr, 16'hFFFE);
    check("t3_int_src", int_src, 1);
    check("t3_bflag", b_flag, 0);
    check("t3_wrinh", wr_inhibit, 0);
    IRQ_n = 1'b1; sr_I = 1'b1;
    vec_fetch = 1'b1; tick(); vec_fetch = 1'b0;
    check("t3_end_in_seq", in_seq, 0);
    tick(3);

    // 4: software BRK
    boundary = 1'b1; opcode_in = 8'h00; settle();
    check("t4_inject", inject, 0);
    check("t4_opcode", opcode_out, 8'h00);
    tick(); boundary = 1'b0;
    check("t4_int_src", int_src, 0);
    check("t4_vec", vec_addr, 16'hFFFE);
    check("t4_bflag", b_flag, 1);
    check("t4_in_seq", in_seq, 1);
    vec_fetch = 1'b1; tick(); vec_fetch = 1'b0;
    check("t4_end_in_seq", in_seq, 0);

    // 5: NMI hijacks an IRQ sequence
    IRQ_n = 1'b0; sr_I = 1'b0;
    tick(3);
    boundary = 1'b1; opcode_in = 8'h18; settle();
    check("t5_inject", inject, 1);
    tick(); boundary = 1'b0; IRQ_n = 1'b1; sr_I = 1'b1;
    check("t5_vec_irq", vec_addr, 16'hFFFE);
    check("t5_src_irq", int_src, 1);
    NMI_n = 1'b0;
    tick(4);
    check("t5_vec_nmi", vec_addr, 16'hFFFA);
    check("t5_src_nmi", int_src, 2);
    check("t5_bflag", b_flag, 0);
    check("t5_in_seq", in_seq, 1);
    vec_fetch = 1'b1; tick(); vec_fetch = 1'b0;
    check("t5_end_in_seq", in_seq, 0);
    check("t5_end_bflag", b_flag, 0);
    boundary = 1'b1; opcode_in = 8'hA9; settle();
    check("t5_pend_cleared", inject, 0);
    tick(); boundary = 1'b0;
    NMI_n = 1'b1;
    tick(3);

    // 6: RDY low freezes sequencing but still catches the NMI edge
    RDY = 1'b0; NMI_n = 1'b0; boundary = 1'b1; opcode_in = 8'hA9;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("t6_frozen_inject", inject, 0);
      tick();
    end
    check("t6_frozen_in_seq", in_seq, 0);
    RDY = 1'b1; settle();
    check("t6_inject", inject, 1);
    tick(); boundary = 1'b0;
    check("t6_src", int_src, 2);
    check("t6_vec", vec_addr, 16'hFFFA);

    // Reset mid-sequence
    RST = 1'b0; tick();
    check("t6_rst_src", int_src, 3);
    check("t6_rst_vec", vec_addr, 16'hFFFC);
    check("t6_rst_in_seq", in_seq, 0);
    check("t6_rst_bflag", b_flag, 0);
    check("t6_rst_wrinh", wr_inhibit, 1);
    boundary = 1'b1; settle();
    check("t6_rst_inject", inject, 0);
    boundary = 1'b0; NMI_n = 1'b1;
    tick(3);
    RST = 1'b1; boundary = 1'b1; settle();
    check("t6_rst_seq_inject", inject, 1);
    tick(); boundary = 1'b0;
    vec_fetch = 1'b1; tick(); vec_fetch = 1'b0;
    boundary = 1'b1; settle();
    check("t6_nmi_discarded", inject, 0);
    tick(); boundary = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
